// File: rtl/ik_swift_host_bridge.sv
// ik_swift_host_bridge
// Avalon-MM slave front end for the ik_swift inverse-kinematics engine. The
// host loads joint configuration, DH parameters and targets, then starts a
// run of 1..255 iterations. Each iteration pulses the engine reset for two
// cycles, enables the engine until it reports done, and captures its DH
// output both as a readable result and as the DH input of the next pass.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   chipselect, address, write, writedata, read
//                       host access; address is a 6-bit word address
//   readdata            registered read data, valid the cycle after read
//   irq                 level interrupt = done_sticky & irq_en
//   ik_en, ik_rst       engine enable / active-high engine reset
//   ik_z, ik_joint_type, ik_dh_dyn_in, ik_target
//                       engine configuration, driven straight from registers
//   ik_done, ik_dh_dyn_out
//                       engine completion flag and result
module ik_swift_host_bridge (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chipselect,
  input  logic [5:0]        address,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              read,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic              ik_en,
  output logic              ik_rst,
  output logic [2:0][17:0]  ik_z,
  output logic [5:0]        ik_joint_type,
  output logic [5:0][20:0]  ik_dh_dyn_in,
  output logic [5:0][35:0]  ik_target,
  input  logic              ik_done,
  input  logic [5:0][20:0]  ik_dh_dyn_out
);

  typedef enum logic [1:0] {S_IDLE, S_ERST, S_RUN, S_CAPT} state_t;

  state_t            r_state, w_next;
  logic              r_erst_cnt;
  logic              r_rst_hold;
  logic [7:0]        r_iter_tgt, r_iter_done;
  logic              r_done_sticky, r_irq_en;
  logic [2:0][17:0]  r_z;
  logic [5:0]        r_jt;
  logic [5:0][20:0]  r_dh_in, r_dh_out;
  logic [5:0][35:0]  r_target;
  logic [31:0]       r_readdata, w_rdata;
  logic              w_wr, w_rd, w_busy, w_start, w_last, w_ctrl_wr;

  assign w_wr      = chipselect & write;
  assign w_rd      = chipselect & read;
  assign w_busy    = (r_state != S_IDLE);
  assign w_ctrl_wr = w_wr && (address == 6'h00);
  assign w_start   = w_ctrl_wr && writedata[0] && !w_busy;
  assign w_last    = ((r_iter_done + 8'd1) == r_iter_tgt);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_ERST;
      S_ERST: if (r_erst_cnt) w_next = S_RUN;
      S_RUN:  if (ik_done) w_next = S_CAPT;
      S_CAPT: w_next = w_last ? S_IDLE : S_ERST;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_erst_cnt <= 1'b0;
      r_rst_hold <= 1'b1;
    end else begin
      r_state    <= w_next;
      // Two-cycle ERST: toggles 0 -> 1 while in ERST, rests at 0 elsewhere.
      r_erst_cnt <= (r_state == S_ERST) ? ~r_erst_cnt : 1'b0;
      r_rst_hold <= 1'b0;
    end
  end

  // r_rst_hold keeps the engine in reset through host reset and releases it
  // on the first clock edge afterwards.
  assign ik_rst = r_rst_hold | (r_state == S_ERST);
  assign ik_en  = (r_state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter_tgt    <= '0;
      r_iter_done   <= '0;
      r_done_sticky <= 1'b0;
      r_irq_en      <= 1'b0;
    end else begin
      if (w_start) begin
        r_iter_tgt  <= (writedata[15:8] == 8'd0) ? 8'd1 : writedata[15:8];
        r_iter_done <= '0;
      end else if (r_state == S_CAPT) begin
        r_iter_done <= r_iter_done + 8'd1;
      end
      // A start issued while busy is dropped entirely, irq_en included.
      if (w_ctrl_wr && !(writedata[0] && w_busy))
        r_irq_en <= writedata[1];
      // Setting on the final capture outranks a clearing STATUS read.
      if ((r_state == S_CAPT) && w_last)
        r_done_sticky <= 1'b1;
      else if (w_start || (w_rd && (address == 6'h01)))
        r_done_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z      <= '0;
      r_jt     <= '0;
      r_dh_in  <= '0;
      r_dh_out <= '0;
      r_target <= '0;
    end else if (r_state == S_CAPT) begin
      r_dh_out <= ik_dh_dyn_out;
      r_dh_in  <= ik_dh_dyn_out;
    end else if (w_wr && !w_busy) begin
      if (address == 6'h05) r_jt <= writedata[5:0];
      for (int i = 0; i < 3; i++)
        if (address == 6'(2 + i)) r_z[i] <= writedata[17:0];
      for (int i = 0; i < 6; i++) begin
        if (address == 6'(8 + i))      r_dh_in[i]         <= writedata[20:0];
        if (address == 6'(16 + 2 * i)) r_target[i][31:0]  <= writedata;
        if (address == 6'(17 + 2 * i)) r_target[i][35:32] <= writedata[3:0];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (address == 6'h01) w_rdata = {16'b0, r_iter_done, 6'b0, r_done_sticky, w_busy};
    if (address == 6'h05) w_rdata[5:0] = r_jt;
    for (int i = 0; i < 3; i++)
      if (address == 6'(2 + i)) w_rdata[17:0] = r_z[i];
    for (int i = 0; i < 6; i++) begin
      if (address == 6'(8 + i))      w_rdata[20:0] = r_dh_in[i];
      if (address == 6'(16 + 2 * i)) w_rdata       = r_target[i][31:0];
      if (address == 6'(17 + 2 * i)) w_rdata[3:0]  = r_target[i][35:32];
      if (address == 6'(32 + i))     w_rdata[20:0] = r_dh_out[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_readdata <= '0;
    else if (w_rd) r_readdata <= w_rdata;
  end

  assign readdata      = r_readdata;
  assign irq           = r_done_sticky & r_irq_en;
  assign ik_z          = r_z;
  assign ik_joint_type = r_jt;
  assign ik_dh_dyn_in  = r_dh_in;
  assign ik_target     = r_target;

endmodule

// File: tb/tb_ik_swift_host_bridge.sv
module tb_ik_swift_host_bridge;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [5:0]        address = '0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              irq, ik_en, ik_rst, ik_done;
  logic [2:0][17:0]  ik_z;
  logic [5:0]        ik_joint_type;
  logic [5:0][20:0]  ik_dh_dyn_in, ik_dh_dyn_out;
  logic [5:0][35:0]  ik_target;

  ik_swift_host_bridge dut (
    .clk(clk), .rst_n(rst_n), .chipselect(chipselect), .address(address),
    .write(write), .writedata(writedata), .read(read), .readdata(readdata),
    .irq(irq), .ik_en(ik_en), .ik_rst(ik_rst), .ik_z(ik_z),
    .ik_joint_type(ik_joint_type), .ik_dh_dyn_in(ik_dh_dyn_in),
    .ik_target(ik_target), .ik_done(ik_done), .ik_dh_dyn_out(ik_dh_dyn_out)
  );

  always #5 clk = ~clk;

  // Engine model: done on the 10th enabled cycle, output = input + 1.
  int m_cnt = 0;
  always @(posedge clk) m_cnt <= ik_en ? m_cnt + 1 : 0;
  assign ik_done = ik_en && (m_cnt == 9);
  always_comb
    for (int j = 0; j < 6; j++) ik_dh_dyn_out[j] = ik_dh_dyn_in[j] + 21'd1;

  // Pulse monitor on the falling edge.
  int en_len = 0, rst_len = 0, en_pulses = 0, rst_pulses = 0;
  int en_bad = 0, rst_bad = 0, last_en_len = 0, last_rst_len = 0;
  logic prev_en = 1'b0, prev_rst = 1'b1, rst_cnted = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en <= 1'b0; prev_rst <= 1'b1; en_len <= 0; rst_len <= 0; rst_cnted <= 1'b0;
    end else begin
      prev_en <= ik_en; prev_rst <= ik_rst;
      if (ik_en) en_len <= en_len + 1;
      else if (prev_en) begin
        en_pulses <= en_pulses + 1; last_en_len <= en_len;
        if (en_len != 10) en_bad <= en_bad + 1;
        en_len <= 0;
      end
      if (ik_rst) begin
        rst_len <= rst_len + 1;
        if (!prev_rst) rst_cnted <= 1'b1;
      end else if (prev_rst) begin
        if (rst_cnted) begin
          rst_pulses <= rst_pulses + 1; last_rst_len <= rst_len;
          if (rst_len != 2) rst_bad <= rst_bad + 1;
        end
        rst_cnted <= 1'b0; rst_len <= 0;
      end
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic cs);
    @(posedge clk); #1;
    chipselect = cs; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_en_pulses(input int tgt);
    int k;
    k = 0;
    while (en_pulses < tgt && k < 500) begin
      @(posedge clk); #1; k++;
    end
    chk("run_complete_timeout", 64'(en_pulses), 64'(tgt));
    repeat (2) begin @(posedge clk); #1; end
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [5:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[14];
  logic [31:0] d;
  logic [20:0] din[6];
  logic [20:0] base[6];
  int          ep0, rp0, eb0, rb0;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{6'h02, 32'hFFFFFFFF, 6'h02, 32'h0003FFFF};
    tbl[1]  = '{6'h03, 32'h00012345, 6'h03, 32'h00012345};
    tbl[2]  = '{6'h04, 32'h0FFC0001, 6'h04, 32'h00000001};
    tbl[3]  = '{6'h05, 32'h000000FF, 6'h05, 32'h0000003F};
    tbl[4]  = '{6'h08, 32'hFFFFFFFF, 6'h08, 32'h001FFFFF};
    tbl[5]  = '{6'h0D, 32'h00054321, 6'h0D, 32'h00054321};
    tbl[6]  = '{6'h14, 32'hFFFFFFFF, 6'h14, 32'hFFFFFFFF};
    tbl[7]  = '{6'h15, 32'hFFFFFFF5, 6'h15, 32'h00000005};
    tbl[8]  = '{6'h15, 32'h0000000A, 6'h15, 32'h0000000A};
    tbl[9]  = '{6'h06, 32'hFFFFFFFF, 6'h06, 32'h00000000};
    tbl[10] = '{6'h3F, 32'hFFFFFFFF, 6'h3F, 32'h00000000};
    tbl[11] = '{6'h1C, 32'h12345678, 6'h1C, 32'h00000000};
    tbl[12] = '{6'h00, 32'h00000000, 6'h01, 32'h00000000};
    tbl[13] = '{6'h20, 32'hFFFFFFFF, 6'h20, 32'h00000000};
    base = '{21'h1FFFFF, 21'h000001, 21'h0ABCDE, 21'h100000, 21'h012345, 21'h1FFFFE};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ik_rst", 64'(ik_rst), 64'd1);
    chk("rst_ik_en", 64'(ik_en), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_readdata", 64'(readdata), 64'd0);
    rst_n = 1'b1;
    chk("ik_rst_held_after_release", 64'(ik_rst), 64'd1);
    @(posedge clk); #1;
    chk("ik_rst_drops_first_edge", 64'(ik_rst), 64'd0);

    // Register write / readback table
    for (int i = 0; i < 14; i++) begin
      wr(tbl[i].addr, tbl[i].wdata, 1'b1);
      rd(tbl[i].raddr, d);
      chk($sformatf("reg_vec[%0d]", i), 64'(d), 64'(tbl[i].exp));
    end
    chk("port_target2", 64'(ik_target[2]), 64'h0000000AFFFFFFFF);
    chk("port_z0", 64'(ik_z[0]), 64'h3FFFF);
    chk("port_joint_type", 64'(ik_joint_type), 64'h3F);
    chk("port_dh_in5", 64'(ik_dh_dyn_in[5]), 64'h54321);

    // Chipselect low: write has no effect
    wr(6'h03, 32'h00000777, 1'b0);
    rd(6'h03, d);
    chk("cs_low_write_ignored", 64'(d), 64'h12345);

    // Single iteration with irq enabled, latency and pulse widths
    for (int j = 0; j < 6; j++) begin
      wr(6'(8 + j), 32'(base[j]), 1'b1);
      din[j] = base[j];
    end
    ep0 = en_pulses; rp0 = rst_pulses;
    wr(6'h00, 32'h00000103, 1'b1);
    chk("lat_c1_rst", 64'({ik_rst, ik_en}), 64'b10);
    @(posedge clk); #1;
    chk("lat_c2_rst", 64'({ik_rst, ik_en}), 64'b10);
    @(posedge clk); #1;
    chk("lat_c3_run", 64'({ik_rst, ik_en}), 64'b01);
    wait_en_pulses(ep0 + 1);
    chk("run1_rst_len", 64'(last_rst_len), 64'd2);
    chk("run1_en_len", 64'(last_en_len), 64'd10);
    chk("run1_rst_pulses", 64'(rst_pulses - rp0), 64'd1);
    chk("run1_irq_high", 64'(irq), 64'd1);
    rd(6'h01, d);
    chk("run1_status", 64'(d), 64'h0102);
    chk("irq_low_after_status_read", 64'(irq), 64'd0);
    rd(6'h01, d);
    chk("status_sticky_cleared", 64'(d), 64'h0100);
    for (int j = 0; j < 6; j++) begin
      din[j] = din[j] + 21'd1;
      rd(6'(32 + j), d);
      chk($sformatf("run1_dh_out[%0d]", j), 64'(d), 64'(din[j]));
      rd(6'(8 + j), d);
      chk($sformatf("run1_dh_in_fb[%0d]", j), 64'(d), 64'(din[j]));
    end

    // Three chained iterations, irq disabled
    ep0 = en_pulses; rp0 = rst_pulses; eb0 = en_bad; rb0 = rst_bad;
    wr(6'h00, 32'h00000301, 1'b1);
    wait_en_pulses(ep0 + 3);
    chk("run3_rst_pulses", 64'(rst_pulses - rp0), 64'd3);
    chk("run3_bad_rst_widths", 64'(rst_bad - rb0), 64'd0);
    chk("run3_bad_en_widths", 64'(en_bad - eb0), 64'd0);
    chk("run3_irq_masked", 64'(irq), 64'd0);
    for (int j = 0; j < 6; j++) begin
      din[j] = din[j] + 21'd3;
      rd(6'(32 + j), d);
      chk($sformatf("run3_dh_out[%0d]", j), 64'(d), 64'(din[j]));
    end
    rd(6'h01, d);
    chk("run3_status", 64'(d), 64'h0302);

    // Config write and start while busy are ignored
    ep0 = en_pulses; rp0 = rst_pulses;
    wr(6'h00, 32'h00000101, 1'b1);
    repeat (4) @(posedge clk);
    wr(6'h08, 32'h00000155, 1'b1);
    wr(6'h02, 32'h00000000, 1'b1);
    wr(6'h00, 32'h00000501, 1'b1);
    wait_en_pulses(ep0 + 1);
    repeat (40) @(posedge clk);
    #1;
    chk("busy_start_no_extra_runs", 64'(en_pulses - ep0), 64'd1);
    chk("busy_start_no_extra_erst", 64'(rst_pulses - rp0), 64'd1);
    din[0] = din[0] + 21'd1;
    rd(6'h08, d);
    chk("busy_dh_in0_unchanged", 64'(d), 64'(din[0]));
    rd(6'h02, d);
    chk("busy_z0_unchanged", 64'(d), 64'h3FFFF);
    rd(6'h01, d);
    chk("busy_status", 64'(d), 64'h0102);

    // irq_en-only CTRL writes; iter_count=0 runs once
    wr(6'h00, 32'h00000002, 1'b1);
    chk("irq_idle_no_done", 64'(irq), 64'd0);
    ep0 = en_pulses;
    wr(6'h00, 32'h00000003, 1'b1);
    wait_en_pulses(ep0 + 1);
    repeat (40) @(posedge clk);
    #1;
    chk("iter0_single_run", 64'(en_pulses - ep0), 64'd1);
    chk("iter0_irq_high", 64'(irq), 64'd1);
    ep0 = en_pulses;
    wr(6'h00, 32'h0000FF00, 1'b1);
    chk("ctrl_nostart_irq_en_off", 64'(irq), 64'd0);
    wr(6'h00, 32'h00000002, 1'b1);
    chk("ctrl_nostart_irq_en_on", 64'(irq), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("ctrl_nostart_no_run", 64'(en_pulses - ep0), 64'd0);
    rd(6'h01, d);
    chk("iter0_status", 64'(d), 64'h0102);
    chk("iter0_irq_cleared", 64'(irq), 64'd0);

    // Reset asserted mid-run
    wr(6'h00, 32'h00000101, 1'b1);
    for (int k = 0; k < 20 && !ik_en; k++) begin @(posedge clk); #1; end
    chk("abort_reached_run", 64'(ik_en), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ik_en", 64'(ik_en), 64'd0);
    chk("abort_ik_rst", 64'(ik_rst), 64'd1);
    chk("abort_readdata", 64'(readdata), 64'd0);
    chk("abort_target2", 64'(ik_target[2]), 64'd0);
    chk("abort_dh_in0", 64'(ik_dh_dyn_in[0]), 64'd0);
    chk("abort_z0", 64'(ik_z[0]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(6'h01, d);
    chk("abort_status", 64'(d), 64'h0);
    rd(6'h20, d);
    chk("abort_no_capture", 64'(d), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ik_swift_host_bridge.md
IK_SWIFT_HOST_BRIDGE -- requirements
Module: ik_swift_host_bridge

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have host ports (Avalon-MM slave, zero wait-state, readdata valid in the cycle after read):
- chipselect  in  1
- address  in  6  word address
- write  in  1
- writedata  in  32
- read  in  1
- readdata  out  32
- irq  out  1  level interrupt
REQ-004 SHALL have engine-side ports (drives the ik_swift modport):
- ik_en  out  1
- ik_rst  out  1  active-high engine reset
- ik_z  out  3x18
- ik_joint_type  out  6
- ik_dh_dyn_in  out  6x21
- ik_target  out  6x36
- ik_done  in  1
- ik_dh_dyn_out  in  6x21

Function
REQ-005 SHALL decode the register map as follows:
- 0x00 CTRL (W): bit0 start; bit1 irq_en; bits15:8 iter_count.
- 0x01 STATUS (R): bit0 busy; bit1 done_sticky; bits15:8 iterations completed.
- 0x02-0x04 z[0..2] (bits17:0).
- 0x05 joint_type (bits5:0).
- 0x08-0x0D dh_dyn_in[0..5] (bits20:0).
- 0x10+2i target[i] bits31:0; 0x11+2i target[i] bits35:32 (from writedata bits3:0), i=0..5.
- 0x20-0x25 dh_dyn_out[0..5] (R).
REQ-006 Register reads SHALL return the stored value zero-extended; unmapped addresses SHALL read 0, and writes to them SHALL be ignored.
REQ-007 Accesses SHALL take effect only when chipselect is high.
REQ-008 Writes to 0x02-0x1B SHALL be ignored while busy.
REQ-009 The ik_z, ik_joint_type, ik_dh_dyn_in and ik_target outputs SHALL be driven directly from their registers.
REQ-010 SHALL implement the FSM IDLE -> ERST -> RUN -> CAPT -> (ERST | IDLE).
REQ-011 IDLE: a CTRL write with bit0=1 SHALL load the iteration target (iter_count, with 0 treated as 1), clear the completed count, clear done_sticky, and enter ERST; busy=1 in every state except IDLE.
REQ-012 ERST: ik_rst SHALL be high for exactly 2 cycles, with ik_en low, then the FSM SHALL enter RUN.
REQ-013 RUN: ik_en SHALL be held high until ik_done is sampled high, then the FSM SHALL enter CAPT; ik_en SHALL be low in CAPT.
REQ-014 CAPT (1 cycle) SHALL perform all of the following:
- copy ik_dh_dyn_out into dh_dyn_out registers and into dh_dyn_in registers (feedback for the next iteration);
- increment the completed count;
- if completed == target, enter IDLE and set done_sticky; else enter ERST.
REQ-015 Latency from the start write to entering RUN SHALL be exactly 3 cycles (1 decode + 2 ERST).
REQ-016 A start write while busy SHALL be ignored, with no state change.
REQ-017 A CTRL write with bit0=0 SHALL update only irq_en.
REQ-018 A STATUS read SHALL clear done_sticky in the cycle after the read; if done_sticky is set in the same cycle as the read, set SHALL win.
REQ-019 irq SHALL equal done_sticky AND irq_en.
REQ-020 The completed count SHALL be 8 bits and SHALL never exceed the target, so no wrap-around occurs.

Reset
REQ-021 While rst_n is low, the following SHALL hold:
- FSM in IDLE;
- ik_en=0, ik_rst=1;
- all data registers, counters, done_sticky, irq_en, irq and readdata = 0.
REQ-022 ik_rst SHALL deassert on the first clock edge after rst_n rises.
REQ-023 Reset asserted mid-run SHALL abort the run immediately, with no capture.

Verification
REQ-024 Start with iter_count=1; the engine model asserts ik_done 10 cycles after ik_en rises -> the bench SHALL check all of:
- ik_rst high for 2 cycles;
- ik_en high for 10 cycles;
- STATUS reads 0x0102;
- dh_dyn_out equals the model output.
REQ-025 iter_count=3 with a model that adds 1 to each joint -> the bench SHALL check:
- 3 ERST/RUN pairs;
- the final dh_dyn_out equals the initial dh_dyn_in+3 per joint;
- the completed count is 3.
REQ-026 Write target[2] lo=0xFFFFFFFF and hi=0xA -> ik_target[2] SHALL be 36'hAFFFFFFFF; a read of 0x15 SHALL return 0x0000000A.
REQ-027 A write to 0x08 and a start, both issued while busy -> dh_dyn_in[0] SHALL be unchanged, and the run SHALL complete only the original iter_count.
REQ-028 With irq_en=1 and a run done, irq SHALL be high; after a STATUS read, irq SHALL be low in the following cycle. A CTRL write of iter_count=0 with start SHALL run exactly 1 iteration.
REQ-029 rst_n pulsed low during RUN -> ik_en=0, ik_rst=1, busy=0 and all registers 0, all within the same cycle, asynchronously.
